pipeline_ctrl: RTL and testbench

Central stall/flush scheduler for the five-stage ARM pipeline. Sits beside the ID stage. Detects read-after-write hazards between the instruction in ID and the instructions in EXE/MEM, and drives the ID stage's `Hazard` input. Sequences multi-cycle data-memory accesses with a wait-state FSM that freezes the whole pipeline, issues IF/ID and ID/EX flushes on taken branches, and keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipeline_ctrl_if.sv | 36 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

   localparam int REG_W        = 4;
   localparam int MEM_WAIT_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch/memory status bundle between the pipeline stages and the scheduler.
import pipe_ctrl_pkg::*;

interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_two_src;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             mem_req;
   logic             exe_branch_taken;
   logic             fwd_en;
   logic             hazard;
   logic             freeze;
   logic             mem_freeze;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, mem_req, exe_branch_taken, fwd_en,
      input  hazard, freeze, mem_freeze, flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, mem_req, exe_branch_taken, fwd_en,
      output hazard, freeze, mem_freeze, flush, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational read-after-write comparator between the ID sources and the
// EXE/MEM destinations; with forwarding only a load-use pair is a hit.
import pipe_ctrl_pkg::*;

module hazard_detect (
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             fwd_en,
   output logic             raw_hit
);
   logic [REG_W-1:0] src [2];
   logic [1:0]       src_en;
   logic [1:0]       src_hit;

   assign src[0] = id_src1;
   assign src[1] = id_src2;
   assign src_en = {id_two_src, 1'b1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         logic exe_match;
         logic mem_match;
         assign exe_match   = (src[gi] == exe_dest) && exe_wb_en;
         assign mem_match   = (src[gi] == mem_dest) && mem_wb_en;
         // Forwarding covers every case except a load whose data is not back yet.
         assign src_hit[gi] = src_en[gi] &&
                              (fwd_en ? (exe_match && exe_mem_r_en)
                                      : (exe_match || mem_match));
      end
   endgenerate

   assign raw_hit = |src_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler: memory wait-state FSM, freeze/flush/hazard priority
// and saturating performance counters.
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
   parameter int MEM_WAIT = MEM_WAIT_DEF,
   parameter int CNT_W    = 16
) (
   input  logic          clk,
   input  logic          rst,
   pipeline_ctrl_if.slave bus
);
   localparam int              ACC_W      = $clog2(MEM_WAIT + 1);
   localparam bit              MULTI      = (MEM_WAIT > 1);
   localparam logic [ACC_W-1:0] LAST_CYC  = ACC_W'(MEM_WAIT);
   localparam logic [ACC_W-1:0] FIRST_BUSY = ACC_W'(2);

   mem_state_t       state_reg, state_next;
   logic [ACC_W-1:0] acc_cyc_reg, acc_cyc_next;
   logic             raw_hit;
   logic             mem_freeze_raw;
   logic             mem_freeze_int;
   logic             flush_int;
   logic             hazard_int;
   logic             freeze_int;

   hazard_detect u_hazard_detect (
      .id_src1      (bus.id_src1),
      .id_src2      (bus.id_src2),
      .id_two_src   (bus.id_two_src),
      .exe_dest     (bus.exe_dest),
      .exe_wb_en    (bus.exe_wb_en),
      .exe_mem_r_en (bus.exe_mem_r_en),
      .mem_dest     (bus.mem_dest),
      .mem_wb_en    (bus.mem_wb_en),
      .fwd_en       (bus.fwd_en),
      .raw_hit      (raw_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_cyc_reg <= '0;
      end else begin
         state_reg   <= state_next;
         acc_cyc_reg <= acc_cyc_next;
      end
   end

   // IDLE with a request is access cycle 1; the last access cycle is unfrozen
   // so the pipeline advances on its edge.
   always_comb begin
      state_next     = state_reg;
      acc_cyc_next   = acc_cyc_reg;
      mem_freeze_raw = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.mem_req && MULTI) begin
               state_next     = BUSY;
               acc_cyc_next   = FIRST_BUSY;
               mem_freeze_raw = 1'b1;
            end
         end
         BUSY: begin
            mem_freeze_raw = (acc_cyc_reg < LAST_CYC);
            if (acc_cyc_reg == LAST_CYC) begin
               state_next   = IDLE;
               acc_cyc_next = '0;
            end else begin
               acc_cyc_next = acc_cyc_reg + 1'b1;
            end
         end
         default: begin
            state_next   = IDLE;
            acc_cyc_next = '0;
         end
      endcase
   end

   // A held branch simply waits out the freeze and flushes afterwards.
   assign mem_freeze_int = mem_freeze_raw && !rst;
   assign flush_int      = bus.exe_branch_taken && !mem_freeze_int && !rst;
   assign hazard_int     = raw_hit && !mem_freeze_int && !flush_int && !rst;
   assign freeze_int     = hazard_int || mem_freeze_int;

   assign bus.mem_freeze = mem_freeze_int;
   assign bus.flush      = flush_int;
   assign bus.hazard     = hazard_int;
   assign bus.freeze     = freeze_int;

   logic [CNT_W-1:0] cnt_reg [2];
   logic [1:0]       cnt_event;

   assign cnt_event = {flush_int, freeze_int};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg[gi] <= '0;
            end else if (cnt_event[gi] && (cnt_reg[gi] != '1)) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign bus.stall_cnt = cnt_reg[0];
   assign bus.flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a MEM_WAIT=4 instance and a MEM_WAIT=1 /
// CNT_W=4 instance share stimulus and are compared to a cycle model each cycle.
module tb_pipeline_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       mem_req, exe_branch_taken, fwd_en;
   bit         check_en;

   int tests = 0;
   int fails = 0;

   pipeline_ctrl_if #(.CNT_W(16)) bus_a ();
   pipeline_ctrl_if #(.CNT_W(4))  bus_b ();

   assign bus_a.id_src1 = id_src1;          assign bus_b.id_src1 = id_src1;
   assign bus_a.id_src2 = id_src2;          assign bus_b.id_src2 = id_src2;
   assign bus_a.id_two_src = id_two_src;    assign bus_b.id_two_src = id_two_src;
   assign bus_a.exe_dest = exe_dest;        assign bus_b.exe_dest = exe_dest;
   assign bus_a.exe_wb_en = exe_wb_en;      assign bus_b.exe_wb_en = exe_wb_en;
   assign bus_a.exe_mem_r_en = exe_mem_r_en; assign bus_b.exe_mem_r_en = exe_mem_r_en;
   assign bus_a.mem_dest = mem_dest;        assign bus_b.mem_dest = mem_dest;
   assign bus_a.mem_wb_en = mem_wb_en;      assign bus_b.mem_wb_en = mem_wb_en;
   assign bus_a.mem_req = mem_req;          assign bus_b.mem_req = mem_req;
   assign bus_a.exe_branch_taken = exe_branch_taken;
   assign bus_b.exe_branch_taken = exe_branch_taken;
   assign bus_a.fwd_en = fwd_en;            assign bus_b.fwd_en = fwd_en;

   pipeline_ctrl #(.MEM_WAIT(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   pipeline_ctrl #(.MEM_WAIT(1), .CNT_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int mw   [2] = '{4, 1};
   int cmax [2] = '{65535, 15};
   int left [2] = '{0, 0};   // access cycles still to run, including the current one
   int m_sc [2] = '{0, 0};
   int m_fc [2] = '{0, 0};

   function automatic bit src_hit(input logic [3:0] s);
      if (fwd_en)
         return (s == exe_dest) && exe_wb_en && exe_mem_r_en;
      return ((s == exe_dest) && exe_wb_en) || ((s == mem_dest) && mem_wb_en);
   endfunction

   function automatic void model_out(input int k, output bit hz, output bit fz,
                                     output bit mf, output bit fl);
      bit raw;
      raw = src_hit(id_src1) || (id_two_src && src_hit(id_src2));
      if (left[k] == 0) mf = mem_req && (mw[k] > 1);
      else              mf = (left[k] > 1);
      fl = exe_branch_taken && !mf;
      hz = raw && !mf && !fl;
      fz = hz || mf;
      if (rst) begin
         hz = 0; fz = 0; mf = 0; fl = 0;
      end
   endfunction

   always @(posedge clk) begin
      bit hz, fz, mf, fl;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else begin
            model_out(k, hz, fz, mf, fl);
            if (fz && m_sc[k] < cmax[k]) m_sc[k]++;
            if (fl && m_fc[k] < cmax[k]) m_fc[k]++;
            if (left[k] == 0) left[k] = mem_req ? mw[k] - 1 : 0;
            else              left[k] = left[k] - 1;
         end
      end
   end

   always @(negedge clk) begin
      bit hz, fz, mf, fl;
      if (check_en) begin
         model_out(0, hz, fz, mf, fl);
         chk("a.hazard", 32'(bus_a.hazard), 32'(hz));
         chk("a.freeze", 32'(bus_a.freeze), 32'(fz));
         chk("a.mem_freeze", 32'(bus_a.mem_freeze), 32'(mf));
         chk("a.flush", 32'(bus_a.flush), 32'(fl));
         chk("a.stall_cnt", 32'(bus_a.stall_cnt), 32'(m_sc[0]));
         chk("a.flush_cnt", 32'(bus_a.flush_cnt), 32'(m_fc[0]));
         model_out(1, hz, fz, mf, fl);
         chk("b.hazard", 32'(bus_b.hazard), 32'(hz));
         chk("b.freeze", 32'(bus_b.freeze), 32'(fz));
         chk("b.mem_freeze", 32'(bus_b.mem_freeze), 32'(mf));
         chk("b.flush", 32'(bus_b.flush), 32'(fl));
         chk("b.stall_cnt", 32'(bus_b.stall_cnt), 32'(m_sc[1]));
         chk("b.flush_cnt", 32'(bus_b.flush_cnt), 32'(m_fc[1]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] b2b_pat;
   logic [3:0] pulse_pat;

   initial begin
      rst = 1'b1;
      id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
      id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
      mem_req = 0; exe_branch_taken = 0; fwd_en = 0;
      check_en = 0;
      b2b_pat   = 8'b0111_0111;   // bit i = cycle i, LSB first: 1,1,1,0,1,1,1,0
      pulse_pat = 4'b0111;

      tick();
      check_en = 1;
      // outputs forced low while reset is held, even with requests present
      mem_req = 1; exe_branch_taken = 1;
      @(negedge clk);
      chk("rst.mem_freeze", 32'(bus_a.mem_freeze), 32'd0);
      chk("rst.flush", 32'(bus_a.flush), 32'd0);
      tick();
      rst = 0; mem_req = 0; exe_branch_taken = 0;
      @(negedge clk);
      chk("rst.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
      chk("rst.hazard", 32'(bus_a.hazard), 32'd0);
      tick();

      // RAW without forwarding
      id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1;
      @(negedge clk);
      chk("nofwd.exe.hazard", 32'(bus_a.hazard), 32'd1);
      chk("nofwd.exe.freeze", 32'(bus_a.freeze), 32'd1);
      tick();
      exe_wb_en = 0; mem_dest = 4'd3; mem_wb_en = 1;
      @(negedge clk);
      chk("nofwd.mem.hazard", 32'(bus_a.hazard), 32'd1);
      tick();
      mem_wb_en = 0;
      @(negedge clk);
      chk("nofwd.none.hazard", 32'(bus_a.hazard), 32'd0);
      tick();

      // forwarding, load-use and id_two_src gating
      fwd_en = 1; exe_dest = 4'd5; exe_wb_en = 1; id_src2 = 4'd5; id_two_src = 1;
      exe_mem_r_en = 0;
      @(negedge clk);
      chk("fwd.alu.hazard", 32'(bus_a.hazard), 32'd0);
      tick();
      exe_mem_r_en = 1;
      @(negedge clk);
      chk("fwd.load.hazard", 32'(bus_a.hazard), 32'd1);
      tick();
      id_two_src = 0;
      @(negedge clk);
      chk("fwd.one_src.hazard", 32'(bus_a.hazard), 32'd0);
      tick();
      fwd_en = 0; exe_wb_en = 0; exe_mem_r_en = 0; id_src2 = '0;

      // single access pulse
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("pulse.c%0d.mem_freeze", i + 1), 32'(bus_a.mem_freeze), 32'(pulse_pat[i]));
         chk($sformatf("pulse.c%0d.b_mem_freeze", i + 1), 32'(bus_b.mem_freeze), 32'd0);
         tick();
         mem_req = 0;
      end

      // back-to-back accesses
      do_reset();
      mem_req = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("b2b.c%0d.mem_freeze", i), 32'(bus_a.mem_freeze), 32'(b2b_pat[i]));
         tick();
      end
      mem_req = 0;
      @(negedge clk);
      chk("b2b.stall_cnt", 32'(bus_a.stall_cnt), 32'd6);
      tick();

      // branch held through a freeze, RAW hit present but never reported
      do_reset();
      mem_req = 1; id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1;
      @(negedge clk);
      chk("br.c1.hazard", 32'(bus_a.hazard), 32'd0);
      tick();
      mem_req = 0; exe_branch_taken = 1;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("br.c%0d.flush", i), 32'(bus_a.flush), 32'(i == 4));
         chk($sformatf("br.c%0d.hazard", i), 32'(bus_a.hazard), 32'd0);
         tick();
      end
      exe_branch_taken = 0; exe_wb_en = 0;
      @(negedge clk);
      chk("br.flush_cnt", 32'(bus_a.flush_cnt), 32'd1);
      chk("br.flush_after", 32'(bus_a.flush), 32'd0);
      tick();

      // reset in access cycle 2 aborts the access
      do_reset();
      mem_req = 1;
      tick();
      mem_req = 0; rst = 1;
      @(negedge clk);
      chk("abort.during.mem_freeze", 32'(bus_a.mem_freeze), 32'd0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("abort.after.mem_freeze", 32'(bus_a.mem_freeze), 32'd0);
      chk("abort.after.freeze", 32'(bus_a.freeze), 32'd0);
      chk("abort.after.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
      tick();
      mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("abort.new.c%0d.mem_freeze", i + 1), 32'(bus_a.mem_freeze), 32'(pulse_pat[i]));
         tick();
         mem_req = 0;
      end

      // counter saturation on the 4-bit instance
      do_reset();
      id_src1 = 4'd9; exe_dest = 4'd9; exe_wb_en = 1;
      repeat (20) tick();
      exe_wb_en = 0;
      @(negedge clk);
      chk("sat.b.stall_cnt", 32'(bus_b.stall_cnt), 32'd15);
      chk("sat.a.stall_cnt", 32'(bus_a.stall_cnt), 32'd20);
      tick();

      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
